// File: rtl/mempool_tile_req_dispatcher_if.sv
// Request bundle between tile request ports and bank ports of the request dispatcher.
// The master side drives the incoming requests and bank ready. The slave side is the dispatcher.
interface mempool_tile_req_dispatcher_if #(
  parameter int unsigned NumInp    = 3,
  parameter int unsigned NumOut    = 16,
  parameter type         payload_t = logic
);
  localparam int unsigned BankW = (NumOut > 1) ? $clog2(NumOut) : 1;

  payload_t               data_i  [NumInp];
  logic     [BankW-1:0]   bank_i  [NumInp];
  logic     [NumInp-1:0]  valid_i;
  logic     [NumInp-1:0]  ready_o;
  payload_t               data_o  [NumOut];
  logic     [NumOut-1:0]  valid_o;
  logic     [NumOut-1:0]  ready_i;

  modport master (
    output data_i, bank_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  data_i, bank_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/mempool_tile_req_dispatcher.sv
// Dispatches requests from NumInp ports to NumOut banks through one holding register per port.
// Each bank arbitrates with fixed lowest-index priority, or age-based priority when MEMPOOL_REQ_DISPATCH_AGE_EN is defined.
module mempool_tile_req_dispatcher #(
  parameter int unsigned NumInp    = 3,
  parameter int unsigned NumOut    = 16,
  parameter int unsigned AgeWidth  = 4,
  parameter type         payload_t = logic
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  mempool_tile_req_dispatcher_if.slave bus
);
  localparam int unsigned BankW = (NumOut > 1) ? $clog2(NumOut) : 1;
  localparam int unsigned IdxW  = (NumInp > 1) ? $clog2(NumInp) : 1;

  if (AgeWidth < 1 || NumInp < 1 || NumOut < 1) begin : g_param_check
    $error("mempool_tile_req_dispatcher: NumInp, NumOut and AgeWidth must be at least 1");
  end

  logic     [NumInp-1:0] r_held;
  logic     [BankW-1:0]  r_bank [NumInp];
  payload_t              r_data [NumInp];

  logic     [NumInp-1:0] w_hit;
  logic     [NumInp-1:0] w_gnt;
  logic     [NumInp-1:0] w_cap;
  logic     [NumOut-1:0] w_any;
  logic     [IdxW-1:0]   w_win [NumOut];

`ifdef MEMPOOL_REQ_DISPATCH_AGE_EN
  logic [AgeWidth-1:0] r_age      [NumInp];
  logic [AgeWidth-1:0] w_best_age [NumOut];
`endif

  // A held bank index that matches no bank can never be granted.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      w_hit[i] = 1'b0;
      for (int b = 0; b < NumOut; b++) begin
        if (r_bank[i] == b[BankW-1:0]) w_hit[i] = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    for (int b = 0; b < NumOut; b++) begin
      w_any[b]       = 1'b0;
      w_win[b]       = '0;
      bus.data_o[b]  = '0;
`ifdef MEMPOOL_REQ_DISPATCH_AGE_EN
      w_best_age[b]  = '0;
`endif
      for (int i = 0; i < NumInp; i++) begin
        if (r_held[i] && r_bank[i] == b[BankW-1:0]) begin
`ifdef MEMPOOL_REQ_DISPATCH_AGE_EN
          // Strictly-greater keeps the lower index on an age tie.
          if (!w_any[b] || r_age[i] > w_best_age[b]) begin
            w_any[b]      = 1'b1;
            w_win[b]      = i[IdxW-1:0];
            w_best_age[b] = r_age[i];
            bus.data_o[b] = r_data[i];
          end
`else
          if (!w_any[b]) begin
            w_any[b]      = 1'b1;
            w_win[b]      = i[IdxW-1:0];
            bus.data_o[b] = r_data[i];
          end
`endif
        end
      end
    end
  end

  // The winner depends only on registered state; ready_i only qualifies the grant.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      w_gnt[i] = 1'b0;
      for (int b = 0; b < NumOut; b++) begin
        if (w_any[b] && bus.ready_i[b] && w_win[b] == i[IdxW-1:0]) w_gnt[i] = 1'b1;
      end
    end
  end

  assign bus.valid_o = w_any;
  assign bus.ready_o = ~r_held | w_gnt;
  assign w_cap       = bus.valid_i & bus.ready_o;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_held <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (w_cap[i])      r_held[i] <= 1'b1;
        else if (w_gnt[i]) r_held[i] <= 1'b0;
      end
    end
  end

  // NOTE: payload and bank registers have no reset; they are only observed while r_held is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumInp; i++) begin
      if (w_cap[i]) begin
        r_bank[i] <= bus.bank_i[i];
        r_data[i] <= bus.data_i[i];
      end
    end
  end

`ifdef MEMPOOL_REQ_DISPATCH_AGE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInp; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (w_cap[i])                                     r_age[i] <= '0;
        else if (r_held[i] && !w_gnt[i] && r_age[i] != '1) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`endif

  // An out-of-range bank index is a protocol violation: the request would be held forever.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int i = 0; i < NumInp; i++) begin
        assert (!(r_held[i] && !w_hit[i]))
          else $error("mempool_tile_req_dispatcher: port %0d holds a bank index >= NumOut", i);
      end
    end
  end
endmodule
